icache: RTL and testbench

Direct-mapped, read-only instruction cache between the datapath fetch port and the memory controller's instruction request port. Instruction hits return in the same cycle. A miss issues exactly one single-word read to the memory controller, fills the frame, and then hits. Hit and miss counters are kept for performance reporting.

---
 rtl/cpu_types_pkg.sv | 24 ++
 rtl/icache.sv | 112 +++++++++++
 tb/tb_icache.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath/cache types: word type, instruction-cache frame layout,
// cache controller states and the default instruction-cache geometry.
package cpu_types_pkg;

  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;

  localparam int ICACHE_SETS  = 16;
  localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
  localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;

  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    word_t                   data;
  } icache_frame_t;

  // Two-bit encoding leaves room for dcache to add write-back states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MISS = 2'd1
  } cache_state_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped, read-only, one-word-per-frame instruction cache with
// same-cycle hits, single-word miss fills and hit/miss performance counters.
module icache
  import cpu_types_pkg::*;
#(
  parameter int SETS  = ICACHE_SETS,
  parameter int IDX_W = $clog2(SETS)
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  imemREN,
  input  word_t imemaddr,
  output logic  ihit,
  output word_t imemload,
  input  logic  iwait,
  input  word_t iload,
  output logic  iREN,
  output word_t iaddr,
  output word_t hit_count,
  output word_t miss_count
);

  localparam int TAG_W = 30 - IDX_W;

  cache_state_t     state_reg, state_next;
  logic [SETS-1:0]  valid_reg;
  logic [TAG_W-1:0] tag_mem [SETS];
  word_t            data_mem [SETS];
  word_t            miss_addr_reg;
  word_t            hit_count_reg;
  word_t            miss_count_reg;

  logic [TAG_W-1:0] req_tag, fill_tag;
  logic [IDX_W-1:0] req_idx, fill_idx;
  logic             lookup_hit;
  logic             start_miss;
  logic             fill;
  logic [1:0]       unused_byte_offset;

  assign req_tag            = imemaddr[31:IDX_W+2];
  assign req_idx            = imemaddr[IDX_W+1:2];
  assign fill_tag           = miss_addr_reg[31:IDX_W+2];
  assign fill_idx           = miss_addr_reg[IDX_W+1:2];
  assign unused_byte_offset = imemaddr[1:0];

  assign lookup_hit = imemREN & valid_reg[req_idx] & (tag_mem[req_idx] == req_tag);

  always_comb begin
    state_next = state_reg;
    ihit       = 1'b0;
    imemload   = '0;
    iREN       = 1'b0;
    iaddr      = '0;
    start_miss = 1'b0;
    fill       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (lookup_hit) begin
          ihit     = 1'b1;
          imemload = data_mem[req_idx];
        end else if (imemREN) begin
          start_miss = 1'b1;
          state_next = MISS;
        end
      end
      MISS: begin
        // The request stays up regardless of imemREN/imemaddr until it returns.
        iREN  = 1'b1;
        iaddr = miss_addr_reg;
        if (!iwait) begin
          fill       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg      <= IDLE;
      valid_reg      <= '0;
      miss_addr_reg  <= '0;
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (start_miss) begin
        miss_addr_reg  <= {imemaddr[31:2], 2'b00};
        miss_count_reg <= miss_count_reg + 32'd1;
      end
      if (ihit) begin
        hit_count_reg <= hit_count_reg + 32'd1;
      end
      if (fill) begin
        valid_reg[fill_idx] <= 1'b1;
      end
    end
  end

  // Tag/data contents are meaningless until valid is set, so they carry no reset.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= iload;
    end
  end

  assign hit_count  = hit_count_reg;
  assign miss_count = miss_count_reg;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_icache;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  nRST;
  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;
  logic  iwait;
  word_t iload;
  logic  iREN;
  word_t iaddr;
  word_t hit_count;
  word_t miss_count;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  word_t hit_offset = '0;

  icache dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iwait(iwait), .iload(iload),
    .iREN(iREN), .iaddr(iaddr), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  // Behavioural model: frames, outstanding miss queue, counters.
  bit          m_valid [16];
  logic [25:0] m_tag   [16];
  word_t       m_data  [16];
  word_t       pending [$];
  word_t       m_hits   = '0;
  word_t       m_misses = '0;

  function automatic bit model_hit(input logic ren, input word_t a);
    return ren && m_valid[a[5:2]] && (m_tag[a[5:2]] == a[31:6]);
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      foreach (m_valid[i]) m_valid[i] = 1'b0;
      pending.delete();
      m_hits   = '0;
      m_misses = '0;
    end else if (pending.size() != 0) begin
      if (!iwait) begin
        m_valid[pending[0][5:2]] = 1'b1;
        m_tag[pending[0][5:2]]   = pending[0][31:6];
        m_data[pending[0][5:2]]  = iload;
        void'(pending.pop_front());
      end
    end else if (model_hit(imemREN, imemaddr)) begin
      m_hits = m_hits + 32'd1;
    end else if (imemREN) begin
      pending.push_back({imemaddr[31:2], 2'b00});
      m_misses = m_misses + 32'd1;
    end
  end

  task automatic chk(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (cmp_en) begin
      logic  e_hit, e_ren;
      word_t e_load, e_addr;
      e_hit = 1'b0; e_ren = 1'b0; e_load = '0; e_addr = '0;
      if (pending.size() != 0) begin
        e_ren  = 1'b1;
        e_addr = pending[0];
      end else if (model_hit(imemREN, imemaddr)) begin
        e_hit  = 1'b1;
        e_load = m_data[imemaddr[5:2]];
      end
      chk("m_ihit", {31'd0, ihit}, {31'd0, e_hit});
      chk("m_imemload", imemload, e_load);
      chk("m_iREN", {31'd0, iREN}, {31'd0, e_ren});
      chk("m_iaddr", iaddr, e_addr);
      chk("m_hit_count", hit_count, m_hits + hit_offset);
      chk("m_miss_count", miss_count, m_misses);
      $display("cyc t=%0t rst=%0b ren=%0b addr=%08h wait=%0b | ihit=%0b load=%08h iREN=%0b iaddr=%08h hits=%0d misses=%0d",
               $time, nRST, imemREN, imemaddr, iwait, ihit, imemload, iREN, iaddr, hit_count, miss_count);
    end
  end

  // Drive one cycle of inputs just after the rising edge, then wait to mid-cycle.
  task automatic step(input logic rn, input logic ren, input word_t a, input logic wt, input word_t ld);
    @(posedge CLK);
    #1;
    nRST = rn; imemREN = ren; imemaddr = a; iwait = wt; iload = ld;
    @(negedge CLK);
  endtask

  initial begin
    nRST = 1'b0; imemREN = 1'b1; imemaddr = 32'h0; iwait = 1'b1; iload = '0;
    @(posedge CLK);
    #1 cmp_en = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_ihit", {31'd0, ihit}, 32'd0);
    chk("rst_iREN", {31'd0, iREN}, 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    chk("rst_hit_count", hit_count, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);

    // Cold miss: three busy cycles then data.
    step(1, 1, 32'h4, 1, 0);
    chk("cold_det_iREN", {31'd0, iREN}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 32'h4, 1, 0);
      chk("cold_iREN", {31'd0, iREN}, 32'd1);
      chk("cold_iaddr", iaddr, 32'h4);
    end
    step(1, 1, 32'h4, 0, 32'h8C220000);
    chk("cold_iREN_last", {31'd0, iREN}, 32'd1);
    chk("cold_miss_count", miss_count, 32'd1);
    step(1, 1, 32'h4, 1, 0);
    chk("cold_hit", {31'd0, ihit}, 32'd1);
    chk("cold_load", imemload, 32'h8C220000);
    chk("cold_hit_count0", hit_count, 32'd0);
    step(1, 0, 32'h4, 1, 0);
    chk("cold_hit_count1", hit_count, 32'd1);
    chk("noreq_ihit", {31'd0, ihit}, 32'd0);
    chk("noreq_load", imemload, 32'd0);

    // Conflict on index 1.
    step(1, 1, 32'h44, 1, 0);
    chk("conf_det_ihit", {31'd0, ihit}, 32'd0);
    step(1, 1, 32'h44, 0, 32'h11111111);
    chk("conf_iaddr", iaddr, 32'h44);
    step(1, 1, 32'h4, 1, 0);
    chk("conf_evicted", {31'd0, ihit}, 32'd0);
    step(1, 1, 32'h4, 0, 32'h8C220000);
    chk("conf_miss_count", miss_count, 32'd3);

    // Address change mid-miss.
    step(1, 1, 32'h10, 1, 0);
    step(1, 1, 32'h20, 1, 0);
    chk("chg_iaddr0", iaddr, 32'h10);
    step(1, 1, 32'h20, 0, 32'hAAAA0010);
    chk("chg_iaddr1", iaddr, 32'h10);
    step(1, 1, 32'h20, 1, 0);
    chk("chg_second_miss", {31'd0, ihit}, 32'd0);
    step(1, 1, 32'h20, 0, 32'hAAAA0020);
    chk("chg_iaddr2", iaddr, 32'h20);
    step(1, 1, 32'h13, 1, 0);
    chk("chg_idx4_hit", {31'd0, ihit}, 32'd1);
    chk("chg_idx4_load", imemload, 32'hAAAA0010);

    // Reset during a miss.
    step(1, 1, 32'h30, 1, 0);
    step(1, 1, 32'h30, 1, 0);
    chk("rmiss_iREN", {31'd0, iREN}, 32'd1);
    #1 nRST = 1'b0;
    #1;
    chk("rmiss_iREN_drop", {31'd0, iREN}, 32'd0);
    chk("rmiss_iaddr", iaddr, 32'd0);
    step(1, 1, 32'h30, 1, 0);
    chk("rmiss_remiss", {31'd0, ihit}, 32'd0);
    chk("rmiss_miss_count", miss_count, 32'd0);
    step(1, 1, 32'h30, 0, 32'h30303030);
    step(1, 1, 32'h30, 1, 0);
    chk("rmiss_hit_load", imemload, 32'h30303030);
    step(1, 1, 32'h4, 1, 0);
    chk("rmiss_4_invalid", {31'd0, ihit}, 32'd0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      logic  rn, ren, wt;
      word_t a;
      rn  = ($urandom_range(0, 199) != 0);
      ren = ($urandom_range(0, 3) != 0);
      wt  = ($urandom_range(0, 2) != 0);
      a   = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 15) == 0) a = a | 32'hFFFF0000;
      step(rn, ren, a, wt, $urandom);
    end

    // Counter wrap: flush any miss, make 0x30 resident, then hit with a saturated count.
    step(1, 0, 32'h0, 0, 32'h0);
    step(1, 1, 32'h30, 1, 0);
    step(1, 1, 32'h30, 0, 32'h5A5A5A5A);
    step(1, 1, 32'h30, 1, 0);
    chk("wrap_hit", {31'd0, ihit}, 32'd1);
    #1;
    force dut.hit_count_reg = 32'hFFFF_FFFF;
    hit_offset = 32'hFFFF_FFFF - m_hits;
    #1;
    release dut.hit_count_reg;
    step(1, 0, 32'h30, 1, 0);
    chk("wrap_hit_count", hit_count, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
